// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Stall arbitration, exception/ERET redirect and stall watchdog
//            for the five-stage MIPS pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h00000040,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned STALL_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0]  ST_RUN       = 2'd0;
  localparam logic [1:0]  ST_FLUSH     = 2'd1;
  localparam logic [1:0]  ST_RECOVER   = 2'd2;
  localparam logic [31:0] ERET_CODE    = 32'h0000000e;
  localparam logic [3:0]  RECOVER_LOAD = 4'(RECOVER_CYCLES);
  localparam logic [15:0] WD_LAST      = 16'(STALL_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [5:0]  stall_vec;
  logic        exc_accept;

  assign exc_accept = (state_q == ST_RUN) && (excepttype_i != 32'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      rcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_RUN: begin
        if (exc_accept) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_RECOVER;
        rcnt_d  = RECOVER_LOAD;
      end
      ST_RECOVER: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic: the deepest stalled stage also holds everything upstream
  always_comb begin
    stall_vec = 6'b000000;
    flush     = (state_q == ST_FLUSH);
    if (state_q == ST_RUN) begin
      if (stallreq_mem)     stall_vec = 6'b011111;
      else if (stallreq_ex) stall_vec = 6'b001111;
      else if (stallreq_id) stall_vec = 6'b000111;
      else if (stallreq_if) stall_vec = 6'b000011;
    end
  end

  always_comb begin
    new_pc_d = new_pc_q;
    if (exc_accept)
      new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

    wd_cnt_d  = 16'd0;
    timeout_d = 1'b0;
    if ((state_q == ST_RUN) && (stall_vec != 6'd0)) begin
      if (wd_cnt_q == WD_LAST) timeout_d = 1'b1;
      else                     wd_cnt_d  = wd_cnt_q + 16'd1;
    end

    stall_cycles_d = stall_cycles_q;
    if ((stall_vec != 6'd0) && (stall_cycles_q != 32'hFFFFFFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_pc_q       <= 32'd0;
      wd_cnt_q       <= 16'd0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      new_pc_q       <= new_pc_d;
      wd_cnt_q       <= wd_cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall         = stall_vec;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign stall_cycles  = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Scoreboard bench for pipe_ctrl (RECOVER_CYCLES=2, STALL_TIMEOUT=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_pc_q[$];
  bit          exp_to_q[$];
  logic [31:0] exp_cnt_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h00000040),
    .RECOVER_CYCLES(2),
    .STALL_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );

  task automatic test_reset();
    rst = 1'b1;
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
    excepttype_i = 32'd0;
    cp0_epc_i    = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'd0) begin failures++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall_cycles got=%h exp=0", stall_cycles); end
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall_priority();
    stallreq_if = 1'b1; stallreq_mem = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin failures++; $display("FAIL prio_mem_if got=%b exp=011111", stall); end
    @(negedge clk);
    stallreq_mem = 1'b0; #1;
    checks++; if (stall !== 6'b000011) begin failures++; $display("FAIL prio_if got=%b exp=000011", stall); end
    @(negedge clk);
    stallreq_if = 1'b0; #1;
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL prio_none got=%b exp=000000", stall); end
    checks++; if (stall_cycles !== 32'd2) begin failures++; $display("FAIL stall_cycles_two got=%0d exp=2", stall_cycles); end
    stallreq_id = 1'b1; #1;
    checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL prio_id got=%b exp=000111", stall); end
    stallreq_ex = 1'b1; #1;
    checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL prio_ex_id got=%b exp=001111", stall); end
    stallreq_id = 1'b0; stallreq_ex = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exception();
    logic [31:0] e;
    cp0_epc_i = 32'h12345678;
    stallreq_ex = 1'b1; excepttype_i = 32'h8;
    exp_pc_q.push_back(32'h00000040);
    @(negedge clk);
    excepttype_i = 32'd0; #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL exc_flush got=%b exp=1", flush); end
    e = exp_pc_q.pop_front();
    checks++; if (new_pc !== e) begin failures++; $display("FAIL exc_new_pc got=%h exp=%h", new_pc, e); end
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL exc_flush_stall got=%b exp=000000", stall); end
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL exc_flush_drop got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h40) begin failures++; $display("FAIL exc_pc_hold got=%h exp=00000040", new_pc); end
    checks++; if (stall !== 6'b0) begin failures++; $display("FAIL recover_stall got=%b exp=000000", stall); end
    excepttype_i = 32'hc;
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL recover1_ignore got=%b exp=0", flush); end
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL recover2_ignore got=%b exp=0", flush); end
    // Back in RUN: the still-pending code is the earliest accepted exception
    stallreq_ex = 1'b0;
    exp_pc_q.push_back(32'h00000040);
    @(negedge clk);
    excepttype_i = 32'd0;
    e = exp_pc_q.pop_front();
    checks++; if (flush !== 1'b1 || new_pc !== e) begin failures++; $display("FAIL exc_earliest got=%b/%h exp=1/%h", flush, new_pc, e); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_eret();
    logic [31:0] e;
    cp0_epc_i = 32'hBFC00100; excepttype_i = 32'he;
    exp_pc_q.push_back(32'hBFC00100);
    @(negedge clk);
    excepttype_i = 32'd0;
    e = exp_pc_q.pop_front();
    checks++; if (flush !== 1'b1 || new_pc !== e) begin failures++; $display("FAIL eret_redirect got=%b/%h exp=1/%h", flush, new_pc, e); end
    cp0_epc_i = 32'h00001234; #1;
    checks++; if (new_pc !== e) begin failures++; $display("FAIL eret_hold_flush got=%h exp=%h", new_pc, e); end
    @(negedge clk);
    checks++; if (new_pc !== e || flush !== 1'b0) begin failures++; $display("FAIL eret_hold_recover got=%b/%h exp=0/%h", flush, new_pc, e); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_codes();
    logic [31:0] codes [4] = '{32'h1, 32'ha, 32'hd, 32'h00400000};
    logic [31:0] e;
    cp0_epc_i = 32'hDEADBEEC;
    for (int i = 0; i < 4; i++) begin
      excepttype_i = codes[i];
      exp_pc_q.push_back(32'h00000040);
      @(negedge clk);
      excepttype_i = 32'd0;
      e = exp_pc_q.pop_front();
      checks++; if (flush !== 1'b1 || new_pc !== e) begin failures++; $display("FAIL code_%h got=%b/%h exp=1/%h", codes[i], flush, new_pc, e); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_watchdog();
    logic [8:0] pat = 9'b001110111;
    bit         e;
    for (int c = 1; c <= 11; c++) exp_to_q.push_back(c == 5 || c == 9);
    stallreq_mem = 1'b1; #1;
    e = exp_to_q.pop_front();
    checks++; if (stall_timeout !== e) begin failures++; $display("FAIL wd_cycle1 got=%b exp=%b", stall_timeout, e); end
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      if (c == 11) stallreq_mem = 1'b0;
      e = exp_to_q.pop_front();
      checks++; if (stall_timeout !== e) begin failures++; $display("FAIL wd_cycle%0d got=%b exp=%b", c, stall_timeout, e); end
    end
    stallreq_mem = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      stallreq_mem = pat[i];
      exp_to_q.push_back(1'b0);
      @(negedge clk);
      e = exp_to_q.pop_front();
      checks++; if (stall_timeout !== e) begin failures++; $display("FAIL wd_restart%0d got=%b exp=%b", i, stall_timeout, e); end
    end
    stallreq_mem = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] e;
    excepttype_i = 32'h8;
    exp_pc_q.push_back(32'h00000040);
    @(negedge clk);
    excepttype_i = 32'd0;
    e = exp_pc_q.pop_front();
    checks++; if (flush !== 1'b1 || new_pc !== e) begin failures++; $display("FAIL rstflush_pre got=%b/%h exp=1/%h", flush, new_pc, e); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (flush !== 1'b0 || new_pc !== 32'd0) begin failures++; $display("FAIL rstflush_clear got=%b/%h exp=0/00000000", flush, new_pc); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rstflush_cycles got=%h exp=0", stall_cycles); end
    excepttype_i = 32'h1;
    exp_pc_q.push_back(32'h00000040);
    @(negedge clk);
    excepttype_i = 32'd0;
    e = exp_pc_q.pop_front();
    checks++; if (flush !== 1'b1 || new_pc !== e) begin failures++; $display("FAIL rstflush_accept got=%b/%h exp=1/%h", flush, new_pc, e); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    force dut.stall_cycles_q = 32'hFFFFFFFD;
    #1;
    release dut.stall_cycles_q;
    #1;
    checks++; if (stall_cycles !== 32'hFFFFFFFD) begin failures++; $display("FAIL sat_preload got=%h exp=fffffffd", stall_cycles); end
    exp_cnt_q.push_back(32'hFFFFFFFE);
    exp_cnt_q.push_back(32'hFFFFFFFF);
    exp_cnt_q.push_back(32'hFFFFFFFF);
    exp_cnt_q.push_back(32'hFFFFFFFF);
    stallreq_id = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_cnt_q.pop_front();
      checks++; if (stall_cycles !== e) begin failures++; $display("FAIL sat_step%0d got=%h exp=%h", i, stall_cycles, e); end
    end
    stallreq_id = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_exception();
    test_eret();
    test_codes();
    test_watchdog();
    test_reset_mid_flush();
    test_saturation();
    checks++; if (exp_pc_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_pc_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
